cmd_addr_sequencer: RTL

CMD_ADDR_SEQUENCER -- requirements
Module: cmd_addr_sequencer

---
 rtl/cmd_addr_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cmd_addr_sequencer.sv
// rtl/cmd_addr_sequencer.sv - NAND command/address latch sequencer: CMD1, address bytes LSB first, optional CMD2.
// Define SEQ_WB_WAIT_EN to add the tWB count and ready/busy wait after CMD2.
module cmd_addr_sequencer (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [7:0]  cmd1,
  input  logic [39:0] addr,
  input  logic [2:0]  addr_cycles,
  input  logic [7:0]  cmd2,
  input  logic        cmd2_valid,
  input  logic        latch_busy,
  input  logic        rb_n,
  output logic        latch_activate,
  output logic [15:0] latch_data,
  output logic        latch_type,
  output logic        ce_n,
  output logic        busy,
  output logic        done
);

`ifdef SEQ_WB_WAIT_EN
  localparam int T_WB = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RELEASE, NEXT, WB, RB, FINISH} state_t;
  logic [3:0] wb_cnt;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RELEASE, NEXT, FINISH} state_t;
  logic unused_rb_n;
  assign unused_rb_n = rb_n;
`endif

  typedef enum logic [1:0] {ITEM_CMD1, ITEM_ADDR, ITEM_CMD2} item_t;

  state_t      state;
  item_t       item;
  logic [39:0] addr_q;
  logic [7:0]  cmd2_q;
  logic        cmd2_valid_q;
  logic [2:0]  n_addr;
  logic [2:0]  idx;

  logic [2:0]  next_idx;
  logic        more_addr;
  logic [39:0] addr_shift;
  logic [2:0]  addr_clamped;

  // Which address byte NEXT would hand out, and whether one is still pending.
  always_comb begin
    next_idx     = (item == ITEM_CMD1) ? 3'd0 : idx + 3'd1;
    more_addr    = (item != ITEM_CMD2) && (next_idx < n_addr);
    addr_shift   = addr_q >> {next_idx, 3'b000};
    addr_clamped = (addr_cycles > 3'd5) ? 3'd5 : addr_cycles;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      item           <= ITEM_CMD1;
      addr_q         <= '0;
      cmd2_q         <= '0;
      cmd2_valid_q   <= 1'b0;
      n_addr         <= '0;
      idx            <= '0;
      latch_activate <= 1'b0;
      latch_data     <= '0;
      latch_type     <= 1'b0;
      ce_n           <= 1'b1;
      done           <= 1'b0;
`ifdef SEQ_WB_WAIT_EN
      wb_cnt         <= '0;
`endif
    end else begin
      latch_activate <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q       <= addr;
            cmd2_q       <= cmd2;
            cmd2_valid_q <= cmd2_valid;
            n_addr       <= addr_clamped;
            idx          <= '0;
            item         <= ITEM_CMD1;
            latch_data   <= {8'h00, cmd1};
            latch_type   <= 1'b1;
            ce_n         <= 1'b0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!latch_busy) begin
            latch_activate <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          if (latch_busy) state <= RELEASE;
        end
        RELEASE: begin
          if (!latch_busy) state <= NEXT;
        end
        NEXT: begin
          if (more_addr) begin
            item       <= ITEM_ADDR;
            idx        <= next_idx;
            latch_data <= {8'h00, addr_shift[7:0]};
            latch_type <= 1'b0;
            state      <= ISSUE;
          end else if (item != ITEM_CMD2 && cmd2_valid_q) begin
            item       <= ITEM_CMD2;
            latch_data <= {8'h00, cmd2_q};
            latch_type <= 1'b1;
            state      <= ISSUE;
`ifdef SEQ_WB_WAIT_EN
          end else if (item == ITEM_CMD2) begin
            wb_cnt <= '0;
            state  <= WB;
`endif
          end else begin
            done  <= 1'b1;
            ce_n  <= 1'b1;
            state <= FINISH;
          end
        end
`ifdef SEQ_WB_WAIT_EN
        WB: begin
          if (wb_cnt == 4'(T_WB - 1)) state <= RB;
          else wb_cnt <= wb_cnt + 4'd1;
        end
        RB: begin
          if (rb_n) begin
            done  <= 1'b1;
            ce_n  <= 1'b1;
            state <= FINISH;
          end
        end
`endif
        // done is visible during FINISH, so start cannot be taken in that cycle.
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
